// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with a per-tenure hold limit.
// The one-hot grant is decoded from a registered winner index, so no req-to-output path exists.
module rr_arbiter4 #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_next;
    logic [1:0]         grant_idx_next;
    logic [1:0]         last_idx, last_idx_next;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_next;
    logic               timeout_next;

    localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_ONE   = CNT_W'(1);

    // Scan p+1, p+2, p+3 and finally p itself; the lowest offset that requests wins.
    function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] r);
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 1; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant_idx <= 2'd0;
            last_idx  <= 2'd3;
            hold_cnt  <= '0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_next;
            grant_idx <= grant_idx_next;
            last_idx  <= last_idx_next;
            hold_cnt  <= hold_cnt_next;
            timeout   <= timeout_next;
        end
    end

    // A release takes priority over the hold limit, so a dropping owner never raises timeout.
    always_comb begin
        state_next     = state;
        grant_idx_next = grant_idx;
        last_idx_next  = last_idx;
        hold_cnt_next  = hold_cnt;
        timeout_next   = 1'b0;

        unique case (state)
            IDLE: begin
                if (req != 4'b0000) begin
                    grant_idx_next = pick(last_idx, req);
                    hold_cnt_next  = HOLD_ONE;
                    state_next     = GRANT;
                end
            end
            GRANT: begin
                if (!req[grant_idx]) begin
                    last_idx_next = grant_idx;
                    if (req != 4'b0000) begin
                        grant_idx_next = pick(grant_idx, req);
                        hold_cnt_next  = HOLD_ONE;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (hold_cnt == HOLD_LIMIT) begin
                    last_idx_next  = grant_idx;
                    timeout_next   = 1'b1;
                    grant_idx_next = pick(grant_idx, req);
                    hold_cnt_next  = HOLD_ONE;
                end else begin
                    hold_cnt_next = hold_cnt + HOLD_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy  = (state == GRANT);
    assign grant = busy ? (4'b0001 << grant_idx) : 4'b0000;

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed bench for rr_arbiter4: one instance at MAX_HOLD=8 and one at MAX_HOLD=1.
module tb_rr_arbiter4;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       busy;
    logic       timeout;

    logic [3:0] req1;
    logic [3:0] grant1;
    logic [1:0] grant_idx1;
    logic       busy1;
    logic       timeout1;

    int check_count = 0;
    int pass_count  = 0;

    rr_arbiter4 #(.MAX_HOLD(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy),
        .timeout   (timeout)
    );

    rr_arbiter4 #(.MAX_HOLD(1), .CNT_W(4)) dut_h1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req1),
        .grant     (grant1),
        .grant_idx (grant_idx1),
        .busy      (busy1),
        .timeout   (timeout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
    task automatic applyStimulus(input logic [3:0] r);
        req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic checkMain(input string tag, input logic [3:0] g, input logic [1:0] idx,
                             input logic b, input logic t);
        checkOutput({tag, ".grant"}, {4'b0, grant}, {4'b0, g});
        checkOutput({tag, ".idx"}, {6'b0, grant_idx}, {6'b0, idx});
        checkOutput({tag, ".busy"}, {7'b0, busy}, {7'b0, b});
        checkOutput({tag, ".timeout"}, {7'b0, timeout}, {7'b0, t});
    endtask

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_i;
        logic       exp_t;

        rst_n = 1'b0;
        req   = 4'b0000;
        req1  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checkMain("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
        checkOutput("reset.h1_grant", {4'b0, grant1}, 8'h00);
        rst_n = 1'b1;

        // Single requester 2: grant next edge, hold three cycles, then idle.
        applyStimulus(4'b0100);
        checkMain("s1.c1", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0100);
        checkMain("s1.c2", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0100);
        checkMain("s1.c3", 4'b0100, 2'd2, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        checkMain("s1.idle", 4'b0000, 2'd2, 1'b0, 1'b0);

        // All four requesting: 8-cycle tenures rotating 0,1,2,3,0.
        pulseReset();
        for (int k = 1; k <= 33; k++) begin
            applyStimulus(4'b1111);
            exp_i = 2'(((k - 1) / 8) % 4);
            exp_g = 4'b0001 << exp_i;
            exp_t = (k > 1) && (((k - 1) % 8) == 0);
            checkMain($sformatf("s2.k%0d", k), exp_g, exp_i, 1'b1, exp_t);
        end
        applyStimulus(4'b0000);
        checkMain("s2.idle", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Owner 1 drops in its third cycle while 0 and 3 request: 3 wins, no bubble.
        pulseReset();
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        checkMain("s3.owner1", 4'b0010, 2'd1, 1'b1, 1'b0);
        applyStimulus(4'b1001);
        checkMain("s3.handoff", 4'b1000, 2'd3, 1'b1, 1'b0);
        applyStimulus(4'b0000);
        checkMain("s3.idle", 4'b0000, 2'd3, 1'b0, 1'b0);

        // Lone requester 2 for 20 cycles: grant steady, timeout at cycles 9 and 17.
        pulseReset();
        for (int k = 1; k <= 20; k++) begin
            applyStimulus(4'b0100);
            exp_t = (k == 9) || (k == 17);
            checkMain($sformatf("s4.k%0d", k), 4'b0100, 2'd2, 1'b1, exp_t);
        end
        applyStimulus(4'b0000);

        // Asynchronous reset mid-tenure, checked before the next clock edge.
        pulseReset();
        applyStimulus(4'b0010);
        applyStimulus(4'b0010);
        checkMain("s5.pre", 4'b0010, 2'd1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        checkMain("s5.async", 4'b0000, 2'd0, 1'b0, 1'b0);
        req = 4'b0011;
        #1;
        rst_n = 1'b1;
        applyStimulus(4'b0011);
        checkMain("s5.first", 4'b0001, 2'd0, 1'b1, 1'b0);
        applyStimulus(4'b0000);

        // MAX_HOLD=1: alternate 0 and 2 every cycle, then a release on a limit cycle.
        pulseReset();
        req1 = 4'b0101;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            exp_g = (k % 2 == 1) ? 4'b0001 : 4'b0100;
            exp_t = (k > 1);
            checkOutput($sformatf("s6.k%0d.grant", k), {4'b0, grant1}, {4'b0, exp_g});
            checkOutput($sformatf("s6.k%0d.timeout", k), {7'b0, timeout1}, {7'b0, exp_t});
        end
        req1 = 4'b0001;
        @(posedge clk);
        #1;
        checkOutput("s6.release.grant", {4'b0, grant1}, 8'b0000_0001);
        checkOutput("s6.release.timeout", {7'b0, timeout1}, 8'h00);
        checkOutput("s6.release.busy", {7'b0, busy1}, 8'h01);
        req1 = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("s6.idle.busy", {7'b0, busy1}, 8'h00);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
